// File: rtl/rtc_spi_pkg.sv
// Shared definitions for the RTC time-word SPI link.
// Holds the 32-bit frame field layout, the packing helper and the transmitter state type.
// Both the transmitter and the VGA-side receiver import this package so the layout is defined
// in exactly one place.
package rtc_spi_pkg;

  localparam int unsigned FRAME_W    = 32;

  localparam int unsigned HEADER_BIT = 31;
  localparam int unsigned YEAR_LSB   = 26;
  localparam int unsigned YEAR_W     = 5;
  localparam int unsigned MONTH_LSB  = 22;
  localparam int unsigned MONTH_W    = 4;
  localparam int unsigned DAY_LSB    = 17;
  localparam int unsigned DAY_W      = 5;
  localparam int unsigned HOUR_LSB   = 12;
  localparam int unsigned HOUR_W     = 5;
  localparam int unsigned MINUTE_LSB = 6;
  localparam int unsigned MINUTE_W   = 6;
  localparam int unsigned SECOND_LSB = 0;
  localparam int unsigned SECOND_W   = 6;

  typedef enum logic [2:0] {
    StIdle,
    StLow,
    StHigh,
    StClow,
    StChigh,
    StGap
  } spi_tx_state_t;

  // Field values are packed unchanged; no range checking is done here.
  function automatic logic [FRAME_W-1:0] pack_time(
    input logic                header,
    input logic [YEAR_W-1:0]   year,
    input logic [MONTH_W-1:0]  month,
    input logic [DAY_W-1:0]    day,
    input logic [HOUR_W-1:0]   hour,
    input logic [MINUTE_W-1:0] minute,
    input logic [SECOND_W-1:0] second
  );
    logic [FRAME_W-1:0] word;
    word                              = '0;
    word[HEADER_BIT]                  = header;
    word[YEAR_LSB   +: YEAR_W]        = year;
    word[MONTH_LSB  +: MONTH_W]       = month;
    word[DAY_LSB    +: DAY_W]         = day;
    word[HOUR_LSB   +: HOUR_W]        = hour;
    word[MINUTE_LSB +: MINUTE_W]      = minute;
    word[SECOND_LSB +: SECOND_W]      = second;
    return word;
  endfunction

endpackage

// File: rtl/spi_time_transmitter.sv
// SPI master that serialises a packed 32-bit time word, MSB first, to the VGA-side receiver.
// Each frame is 32 data pulses plus one commit pulse (sdi=0), followed by a long sclk-low gap
// that resets the receiver's bit counter. Reset also runs a full gap before the first accept.
//
// Ports:
//   clk, reset_n        40 MHz clock, asynchronous active-low reset
//   valid / ready       request handshake; accept on valid && ready at a rising clk edge
//   header..second      time fields, sampled only on the accept edge
//   busy                ~ready
//   sclk, sdi           registered SPI clock (idles low) and data
module spi_time_transmitter
  import rtc_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 16,
  parameter int unsigned GAP_CYCLES  = 10000,
  parameter int unsigned FRAME_BITS  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid,
  output logic                ready,
  input  logic                header,
  input  logic [YEAR_W-1:0]   year,
  input  logic [MONTH_W-1:0]  month,
  input  logic [DAY_W-1:0]    day,
  input  logic [HOUR_W-1:0]   hour,
  input  logic [MINUTE_W-1:0] minute,
  input  logic [SECOND_W-1:0] second,
  output logic                busy,
  output logic                sclk,
  output logic                sdi
);

  localparam int unsigned PhW  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);

  // The receiver resets its bit counter after 8000 idle cycles; a shorter gap never resyncs it.
  if (GAP_CYCLES <= 8000) begin : g_gap_check
    $error("GAP_CYCLES must exceed the receiver's 8000-cycle reset threshold");
  end

  spi_tx_state_t      state_q, state_d;
  logic [PhW-1:0]     phase_q, phase_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sclk_q, sclk_d;
  logic               sdi_q, sdi_d;
  logic               phase_last;

  assign phase_last = (phase_q == PhW'(HALF_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    unique case (state_q)
      StIdle: begin
        if (valid) begin
          shreg_d = pack_time(header, year, month, day, hour, minute, second);
          bit_d   = '0;
          phase_d = '0;
          state_d = StLow;
        end
      end
      StLow: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = StHigh;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StHigh: begin
        if (phase_last) begin
          phase_d = '0;
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          bit_d   = bit_q + BitW'(1);
          state_d = (bit_d == BitW'(FRAME_BITS)) ? StClow : StLow;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StClow: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = StChigh;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StChigh: begin
        if (phase_last) begin
          phase_d = '0;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        gap_d   = '0;
        state_d = StGap;
      end
    endcase

    // Outputs are registered from the next state, so sdi only moves on the edge where sclk
    // falls or stays low; the shift on HIGH exit lands together with the falling edge.
    sclk_d = (state_d == StHigh) || (state_d == StChigh);
    sdi_d  = ((state_d == StLow) || (state_d == StHigh)) ? shreg_d[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StGap;
      phase_q <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = ~ready;
  assign sclk  = sclk_q;
  assign sdi   = sdi_q;

endmodule
